// File: rtl/seq_alu_if.sv
// Handshake and data bundle between an operand producer/result consumer and seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       opS;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R;
  logic [3:0]       flags;

  modport master (
    output in_valid, opA, opB, opS, out_ready,
    input  in_ready, out_valid, R, flags
  );

  modport slave (
    input  in_valid, opA, opB, opS, out_ready,
    output in_ready, out_valid, R, flags
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic, bit-serial shifts and shift-add multiply.
// state | meaning
// IDLE  | ready for an operand set, no result presented
// BUSY  | iterating a shift (one bit per cycle) or multiply (one multiplier bit per cycle)
// DONE  | result and flags presented until the consumer takes them
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  generate
    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : gWidthCheck
      $error("seq_alu: WIDTH must be a power of two and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT              state, stateNext;
  logic [2:0]         opReg;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   work;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rReg;
  logic [3:0]         flagsReg;

  logic               accept;
  logic               lastIter;
  logic               isShift;
  logic               goBusy;
  logic [SW-1:0]      nCount;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   aluR;
  logic               aluC;
  logic               aluV;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   workShl;
  logic [WIDTH-1:0]   workShr;
  logic [WIDTH-1:0]   iterR;
  logic               iterC;

  assign accept   = bus.in_valid && (state == IDLE);
  assign lastIter = (cnt == CW'(1));
  assign nCount   = bus.opB[SW-1:0];
  assign isShift  = (bus.opS == 3'b101) || (bus.opS == 3'b110);
  assign goBusy   = (bus.opS == 3'b111) || (isShift && nCount != '0);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.R         = rReg;
  assign bus.flags     = flagsReg;

  // Single-cycle result for ops that finish at accept (shift by zero passes opA through).
  always_comb begin
    aluR = '0;
    aluC = 1'b0;
    aluV = 1'b0;
    sum  = {1'b0, bus.opA} + {1'b0, bus.opB};
    diff = {1'b0, bus.opA} - {1'b0, bus.opB};
    case (bus.opS)
      3'b000: begin
        aluR = sum[WIDTH-1:0];
        aluC = sum[WIDTH];
        aluV = (bus.opA[WIDTH-1] == bus.opB[WIDTH-1]) && (sum[WIDTH-1] != bus.opA[WIDTH-1]);
      end
      3'b001: begin
        aluR = diff[WIDTH-1:0];
        aluC = diff[WIDTH];
        aluV = (bus.opA[WIDTH-1] != bus.opB[WIDTH-1]) && (diff[WIDTH-1] != bus.opA[WIDTH-1]);
      end
      3'b010:  aluR = bus.opA & bus.opB;
      3'b011:  aluR = bus.opA | bus.opB;
      3'b100:  aluR = bus.opA ^ bus.opB;
      default: aluR = bus.opA;
    endcase
  end

  // One iteration step of the captured shift or multiply.
  always_comb begin
    accNext = acc + (work[0] ? mcand : '0);
    workShl = {work[WIDTH-2:0], 1'b0};
    workShr = {1'b0, work[WIDTH-1:1]};
    iterR   = '0;
    iterC   = 1'b0;
    case (opReg)
      3'b101: begin
        iterR = workShl;
        iterC = work[WIDTH-1];
      end
      3'b110: begin
        iterR = workShr;
        iterC = work[0];
      end
      default: begin
        iterR = accNext[WIDTH-1:0];
        iterC = |accNext[2*WIDTH-1:WIDTH];
      end
    endcase
  end

  // FSM next-state decode.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = goBusy ? BUSY : DONE;
      BUSY:    if (lastIter) stateNext = DONE;
      DONE:    if (bus.out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Operand capture, iteration datapath and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opReg    <= '0;
      cnt      <= '0;
      work     <= '0;
      mcand    <= '0;
      acc      <= '0;
      rReg     <= '0;
      flagsReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opReg <= bus.opS;
            if (goBusy) begin
              work  <= (bus.opS == 3'b111) ? bus.opB : bus.opA;
              mcand <= {{WIDTH{1'b0}}, bus.opA};
              acc   <= '0;
              cnt   <= (bus.opS == 3'b111) ? CW'(WIDTH) : CW'(nCount);
            end else begin
              rReg     <= aluR;
              flagsReg <= {aluR[WIDTH-1], aluV, aluC, aluR == '0};
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (opReg == 3'b111) begin
            acc   <= accNext;
            mcand <= {mcand[2*WIDTH-2:0], 1'b0};
            work  <= workShr;
          end else begin
            work <= (opReg == 3'b101) ? workShl : workShr;
          end
          if (lastIter) begin
            rReg     <= iterR;
            flagsReg <= {iterR[WIDTH-1], 1'b0, iterC, iterR == '0};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_alu_if #(.WIDTH(8)) bus ();

  seq_alu #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand set, measure latency, check result, then release it.
  task automatic doOp(input string tag, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] expR, input logic [3:0] expF,
                      input int expL);
    int lat;
    bus.in_valid  = 1'b1;
    bus.opS       = op;
    bus.opA       = a;
    bus.opB       = b;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.opA      = ~a;
    bus.opB      = ~b;
    bus.opS      = ~op;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(expL));
    chk({tag, " R"}, 32'(bus.R), 32'(expR));
    chk({tag, " flags"}, 32'(bus.flags), 32'(expF));
    chk({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " released"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.opA       = '0;
    bus.opB       = '0;
    bus.opS       = '0;
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset R", 32'(bus.R), 32'd0);
    chk("reset flags", 32'(bus.flags), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    doOp("add 100+50", 3'b000, 8'd100, 8'd50, 8'd150, 4'b1100, 1);
    doOp("sub 50-100", 3'b001, 8'd50, 8'd100, 8'd206, 4'b1010, 1);
    doOp("sub 100-100", 3'b001, 8'd100, 8'd100, 8'd0, 4'b0001, 1);
    doOp("add ff+01", 3'b000, 8'hFF, 8'h01, 8'h00, 4'b0011, 1);
    doOp("add 7f+01", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1100, 1);
    doOp("and", 3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
    doOp("or", 3'b011, 8'h0F, 8'h80, 8'h8F, 4'b1000, 1);
    doOp("mul 100*50", 3'b111, 8'd100, 8'd50, 8'h88, 4'b1010, 9);
    doOp("mul ff*ff", 3'b111, 8'hFF, 8'hFF, 8'h01, 4'b0010, 9);
    doOp("mul 15*17", 3'b111, 8'd15, 8'd17, 8'hFF, 4'b1000, 9);
    doOp("shl 100<<3", 3'b101, 8'd100, 8'd3, 8'd32, 4'b0010, 4);
    doOp("shr 100>>0", 3'b110, 8'd100, 8'd0, 8'd100, 4'b0000, 1);
    doOp("shr 81>>1 cnt masked", 3'b110, 8'h81, 8'h09, 8'h40, 4'b0010, 2);
    doOp("shl 80<<7", 3'b101, 8'h80, 8'd7, 8'h00, 4'b0001, 8);

    // Backpressure on an XOR result.
    bus.in_valid = 1'b1;
    bus.opS      = 3'b100;
    bus.opA      = 8'hF0;
    bus.opB      = 8'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.opA      = 8'h00;
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp R", 32'(bus.R), 32'h0F);
      chk("bp flags", 32'(bus.flags), 32'h0);
      chk("bp in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp released", 32'({bus.out_valid, bus.in_ready}), 32'b01);

    // Reset in the middle of a multiply.
    bus.in_valid = 1'b1;
    bus.opS      = 3'b111;
    bus.opA      = 8'd100;
    bus.opB      = 8'd50;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort R", 32'(bus.R), 32'd0);
    chk("abort flags", 32'(bus.flags), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("abort no result", 32'(bus.out_valid), 32'd0);
    end
    doOp("add 1+1 after reset", 3'b000, 8'd1, 8'd1, 8'd2, 4'b0000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
